// File: rtl/mseq_code_scheduler.sv
// rtl/mseq_code_scheduler.sv - round-robin scheduler sharing one M-sequence generator among requesters
// Grants one code phase per request, forwards the owner's chips and guards each phase with watchdogs.
module mseq_code_scheduler #(
   parameter int NUM_REQ   = 4,
   parameter int N         = 63,
   parameter int LENGTH    = $clog2(N),
   parameter int HOLD      = 3,
   parameter int START_TMO = 8,
   parameter int RUN_TMO   = N*HOLD+16
) (
   input  logic                        clkin,
   input  logic                        rstn,
   input  logic [NUM_REQ-1:0]          req_i,
   input  logic [NUM_REQ*LENGTH-1:0]   req_code_i,
   output logic [NUM_REQ-1:0]          grant_o,
   output logic [NUM_REQ-1:0]          done_o,
   output logic                        gen_valid_o,
   output logic [LENGTH-1:0]           gen_code_o,
   input  logic                        gen_ready_i,
   input  logic                        gen_strobe_i,
   input  logic                        gen_out_i,
   output logic                        chip_o,
   output logic                        chip_valid_o,
   output logic [$clog2(NUM_REQ)-1:0]  chip_owner_o,
   output logic                        busy_o,
   output logic                        tmo_err_o,
   input  logic                        err_clr_i
);
   localparam int OW = $clog2(NUM_REQ);
   localparam int WW = $clog2(RUN_TMO + START_TMO + 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_START, S_RUN, S_DONE} state_t;

   state_t              state_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [NUM_REQ-1:0]  done_q;
   logic                gen_valid_q;
   logic [LENGTH-1:0]   gen_code_q;
   logic                chip_q;
   logic                chip_valid_q;
   logic [OW-1:0]       owner_q;
   logic [OW-1:0]       rr_q;
   logic                busy_q;
   logic                tmo_err_q;
   logic [WW-1:0]       wdog_q;
   logic [OW-1:0]       win_idx;

   // First active request at or after the pointer, wrapping around.
   function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [OW-1:0] ptr);
      logic [OW-1:0] pick;
      logic          found;
      int            j;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req[j]) begin
            found = 1'b1;
            pick  = OW'(j);
         end
      end
      return pick;
   endfunction

   assign win_idx = rr_pick(req_i, rr_q);

   always_ff @(posedge clkin) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         done_q       <= '0;
         gen_valid_q  <= 1'b0;
         gen_code_q   <= '0;
         chip_q       <= 1'b0;
         chip_valid_q <= 1'b0;
         owner_q      <= '0;
         rr_q         <= '0;
         busy_q       <= 1'b0;
         tmo_err_q    <= 1'b0;
         wdog_q       <= '0;
      end else begin
         done_q <= '0;
         // A timeout assigned later in this block overrides the clear.
         if (err_clr_i) tmo_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (|req_i && gen_ready_i) begin
                  owner_q     <= win_idx;
                  grant_q     <= NUM_REQ'(1) << win_idx;
                  gen_code_q  <= req_code_i[win_idx*LENGTH +: LENGTH];
                  gen_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               gen_valid_q <= 1'b0;
               wdog_q      <= '0;
               state_q     <= S_WAIT_START;
            end
            S_WAIT_START: begin
               if (!gen_ready_i) begin
                  wdog_q  <= '0;
                  state_q <= S_RUN;
               end else if (wdog_q == WW'(START_TMO-1)) begin
                  tmo_err_q <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            S_RUN: begin
               chip_q       <= gen_out_i;
               chip_valid_q <= gen_strobe_i;
               if (gen_ready_i) begin
                  state_q <= S_DONE;
               end else if (wdog_q == WW'(RUN_TMO-1)) begin
                  tmo_err_q <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            S_DONE: begin
               done_q       <= grant_q;
               grant_q      <= '0;
               chip_valid_q <= 1'b0;
               rr_q         <= (owner_q == OW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
               busy_q       <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign grant_o      = grant_q;
   assign done_o       = done_q;
   assign gen_valid_o  = gen_valid_q;
   assign gen_code_o   = gen_code_q;
   assign chip_o       = chip_q;
   assign chip_valid_o = chip_valid_q;
   assign chip_owner_o = owner_q;
   assign busy_o       = busy_q;
   assign tmo_err_o    = tmo_err_q;
endmodule

// File: tb/tb_mseq_code_scheduler.sv
// tb/tb_mseq_code_scheduler.sv - scoreboard bench for the M-sequence code scheduler
// A behavioural generator model feeds chips; expected grants and chips are queued as stimulus is issued.
module tb_mseq_code_scheduler;
   localparam int NUM_REQ   = 4;
   localparam int N         = 63;
   localparam int LENGTH    = 6;
   localparam int HOLD      = 3;
   localparam int START_TMO = 8;
   localparam int RUN_TMO   = N*HOLD+16;
   localparam int OW        = 2;

   logic                       clkin, rstn;
   logic [NUM_REQ-1:0]         req_i;
   logic [NUM_REQ*LENGTH-1:0]  req_code_i;
   logic [NUM_REQ-1:0]         grant_o, done_o;
   logic                       gen_valid_o;
   logic [LENGTH-1:0]          gen_code_o;
   logic                       gen_ready_i, gen_strobe_i, gen_out_i;
   logic                       chip_o, chip_valid_o;
   logic [OW-1:0]              chip_owner_o;
   logic                       busy_o, tmo_err_o, err_clr_i;

   mseq_code_scheduler #(.NUM_REQ(NUM_REQ), .N(N), .LENGTH(LENGTH), .HOLD(HOLD),
                         .START_TMO(START_TMO), .RUN_TMO(RUN_TMO)) dut (
      .clkin(clkin), .rstn(rstn), .req_i(req_i), .req_code_i(req_code_i),
      .grant_o(grant_o), .done_o(done_o), .gen_valid_o(gen_valid_o), .gen_code_o(gen_code_o),
      .gen_ready_i(gen_ready_i), .gen_strobe_i(gen_strobe_i), .gen_out_i(gen_out_i),
      .chip_o(chip_o), .chip_valid_o(chip_valid_o), .chip_owner_o(chip_owner_o),
      .busy_o(busy_o), .tmo_err_o(tmo_err_o), .err_clr_i(err_clr_i));

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   typedef struct { logic [OW-1:0] owner; logic [LENGTH-1:0] code; bit chips; } grant_t;
   typedef struct { logic [OW-1:0] owner; logic bit_v; } chip_t;

   grant_t gq[$];
   chip_t  cq[$];
   grant_t g;
   chip_t  c;
   logic   seq_b [0:N-1];
   int     n_checks = 0;
   int     n_errs   = 0;
   int     gen_mode;
   bit     gen_abort;
   bit     g_active;
   int     g_cnt, g_code, k;
   logic   prev_gv;
   logic [5:0] lfsr;
   logic [NUM_REQ-1:0] oh;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clkin);
   endtask

   task automatic wait_gv(input string tag);
      int t = 0;
      while (!gen_valid_o && t < 50) begin @(negedge clkin); t++; end
      chk({tag, "_gv_seen"}, gen_valid_o, 1);
   endtask

   task automatic wait_done(input string tag, input logic [NUM_REQ-1:0] exp);
      int t = 0;
      while (done_o == '0 && t < 400) begin @(negedge clkin); t++; end
      chk(tag, done_o, exp);
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_grant"}, grant_o, 0);
      chk({p, "_done"}, done_o, 0);
      chk({p, "_gen_valid"}, gen_valid_o, 0);
      chk({p, "_gen_code"}, gen_code_o, 0);
      chk({p, "_chip"}, chip_o, 0);
      chk({p, "_chip_valid"}, chip_valid_o, 0);
      chk({p, "_owner"}, chip_owner_o, 0);
      chk({p, "_busy"}, busy_o, 0);
      chk({p, "_tmo"}, tmo_err_o, 0);
   endtask

   // Monitor first, then generator model, both on the falling edge.
   initial begin
      lfsr = 6'b000001;
      for (int i = 0; i < N; i++) begin
         seq_b[i] = lfsr[0];
         lfsr = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
      end
      gen_ready_i = 1'b1; gen_strobe_i = 1'b0; gen_out_i = 1'b0;
      g_active = 1'b0; prev_gv = 1'b0; g_cnt = 0; g_code = 0;
      forever begin
         @(negedge clkin);
         if (gen_valid_o) begin
            chk("gv_while_ready", gen_ready_i, 1);
            chk("gv_one_clk", prev_gv, 0);
            chk("gv_with_done", done_o, 0);
            if (gq.size() == 0) chk("unexpected_grant", grant_o, 0);
            else begin
               g  = gq.pop_front();
               oh = NUM_REQ'(1) << g.owner;
               chk("grant_onehot", grant_o, oh);
               chk("grant_code", gen_code_o, g.code);
               chk("grant_owner", chip_owner_o, g.owner);
               chk("grant_busy", busy_o, 1);
               if (g.chips)
                  for (int j = 0; j < N; j++) cq.push_back('{g.owner, seq_b[(int'(g.code) + j) % N]});
            end
         end
         prev_gv = gen_valid_o;
         if (chip_valid_o) begin
            if (cq.size() == 0) chk("unexpected_chip", chip_valid_o, 0);
            else begin
               c = cq.pop_front();
               chk("chip_value", chip_o, c.bit_v);
               chk("chip_owner", chip_owner_o, c.owner);
            end
         end
         if (gen_abort) g_active = 1'b0;
         if (!g_active) begin
            gen_ready_i = 1'b1; gen_strobe_i = 1'b0; gen_out_i = 1'b0;
            if (gen_valid_o && !gen_abort) begin
               g_active = (gen_mode != 1);
               g_code   = int'(gen_code_o);
               g_cnt    = 0;
               if (gen_mode != 1) gen_ready_i = 1'b0;
            end
         end else if (gen_mode == 0) begin
            g_cnt++;
            if (g_cnt >= 2 && g_cnt - 2 < N*HOLD) begin
               gen_strobe_i = ((g_cnt - 2) % HOLD == 0);
               gen_out_i    = seq_b[(g_code + (g_cnt - 2) / HOLD) % N];
            end else if (g_cnt - 2 >= N*HOLD) begin
               gen_ready_i = 1'b1; gen_strobe_i = 1'b0; g_active = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      rstn = 1'b0; req_i = '0; err_clr_i = 1'b0; gen_mode = 0; gen_abort = 1'b0;
      req_code_i = {6'd62, 6'd33, 6'd0, 6'd5};
      tick(3);
      chk_reset("reset");
      rstn = 1'b1;
      tick(1);

      // Single requester 1 with code 0.
      gq.push_back('{2'd1, 6'd0, 1'b1});
      req_i = 4'b0010;
      tick(1);
      chk("t1_latency", gen_valid_o, 1);
      wait_done("t1_done", 4'b0010);
      chk("t1_all_chips", cq.size(), 0);
      req_i = '0;
      tick(1);
      chk("t1_done_1clk", done_o, 0);
      chk("t1_grant_clear", grant_o, 0);
      chk("t1_busy_clear", busy_o, 0);

      // All four requesting from a reset pointer.
      rstn = 1'b0; tick(1); rstn = 1'b1; tick(1);
      gq.push_back('{2'd0, 6'd5, 1'b1});
      gq.push_back('{2'd1, 6'd0, 1'b1});
      gq.push_back('{2'd2, 6'd33, 1'b1});
      gq.push_back('{2'd3, 6'd62, 1'b1});
      gq.push_back('{2'd0, 6'd5, 1'b1});
      req_i = 4'hf;
      for (int i = 0; i < 5; i++) begin
         oh = NUM_REQ'(1) << (i % NUM_REQ);
         wait_done("t2_done", oh);
         if (i == 4) req_i = '0;
         tick(1);
      end
      chk("t2_grants_left", gq.size(), 0);
      chk("t2_chips_left", cq.size(), 0);

      // Generator never drops ready: start watchdog, then next requester served.
      gen_mode = 1;
      gq.push_back('{2'd2, 6'd33, 1'b0});
      gq.push_back('{2'd0, 6'd5, 1'b1});
      req_i = 4'b0101;
      wait_gv("t3");
      k = 0;
      while (!tmo_err_o && k < 50) begin tick(1); k++; end
      chk("t3_start_tmo_clks", k, START_TMO + 1);
      gen_mode = 0;
      wait_done("t3_done", 4'b0100);
      req_i = 4'b0001;
      tick(1);
      wait_done("t3_next_done", 4'b0001);
      req_i = '0;
      chk("t3_chips_left", cq.size(), 0);
      chk("t3_tmo_sticky", tmo_err_o, 1);
      tick(1);
      err_clr_i = 1'b1; tick(1); err_clr_i = 1'b0;
      chk("t3_err_clr", tmo_err_o, 0);

      // Generator stalls in RUN.
      gen_mode = 2;
      gq.push_back('{2'd3, 6'd62, 1'b0});
      req_i = 4'b1000;
      wait_gv("t4");
      k = 0;
      while (!tmo_err_o && k < 300) begin tick(1); k++; end
      chk("t4_run_tmo_clks", k, RUN_TMO + 2);
      wait_done("t4_done", 4'b1000);
      req_i = '0; gen_abort = 1'b1; tick(1); gen_abort = 1'b0;
      err_clr_i = 1'b1; tick(1); err_clr_i = 1'b0;
      chk("t4_err_clr", tmo_err_o, 0);
      gq.push_back('{2'd3, 6'd62, 1'b0});
      req_i = 4'b1000;
      wait_gv("t4b");
      tick(RUN_TMO + 1);
      chk("t4b_tmo_pre", tmo_err_o, 0);
      err_clr_i = 1'b1; tick(1); err_clr_i = 1'b0;
      chk("t4b_set_beats_clr", tmo_err_o, 1);
      wait_done("t4b_done", 4'b1000);
      req_i = '0; gen_mode = 0; gen_abort = 1'b1; tick(1); gen_abort = 1'b0;
      err_clr_i = 1'b1; tick(1); err_clr_i = 1'b0;

      // Owner drops its request mid-RUN; code is sampled only at grant.
      gq.push_back('{2'd0, 6'd5, 1'b1});
      req_i = 4'b0001;
      wait_gv("t5");
      tick(20);
      req_i = '0;
      wait_done("t5_done", 4'b0001);
      chk("t5_chips_left", cq.size(), 0);
      tick(1);
      req_code_i[1*LENGTH +: LENGTH] = 6'd9;
      gq.push_back('{2'd1, 6'd9, 1'b1});
      req_i = 4'b0011;
      wait_gv("t5b");
      req_code_i[1*LENGTH +: LENGTH] = 6'd20;
      tick(5);
      chk("t5b_code_hold", gen_code_o, 9);
      wait_done("t5b_ptr_done", 4'b0010);
      req_i = '0;
      tick(1);

      // One-clock reset mid-RUN.
      gq.push_back('{2'd2, 6'd33, 1'b1});
      req_i = 4'b0100;
      wait_gv("t6");
      tick(30);
      rstn = 1'b0; req_i = '0;
      tick(1);
      chk_reset("t6_midrun");
      rstn = 1'b1;
      cq.delete();
      gen_abort = 1'b1; tick(1); gen_abort = 1'b0;
      chk("t6_no_done", done_o, 0);
      gq.push_back('{2'd0, 6'd5, 1'b1});
      req_i = 4'b0101;
      wait_gv("t6b");
      wait_done("t6b_ptr_reset", 4'b0001);
      req_i = '0;
      tick(2);
      chk("end_grants_left", gq.size(), 0);
      chk("end_chips_left", cq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
